// File: rtl/rename_table.sv
// Register alias table: tracks, per architectural register, whether the newest
// producer is still in the ROB and which ROB entry it is; feeds dispatch operand steering.
module rename_table #(
  parameter int ARF_N_ENTRIES = 32,
  parameter int ROB_N_ENTRIES = 16,
  localparam int AW = $clog2(ARF_N_ENTRIES),
  localparam int RW = $clog2(ROB_N_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] src1_arf_id,
  output logic          src1_renamed,
  output logic [RW-1:0] src1_rob_id,
  input  logic [AW-1:0] src2_arf_id,
  output logic          src2_renamed,
  output logic [RW-1:0] src2_rob_id,
  input  logic          dispatch_fire,
  input  logic          dispatch_dst_valid,
  input  logic [AW-1:0] dispatch_dst_arf_id,
  input  logic [RW-1:0] dispatch_rob_id,
  input  logic          retire,
  input  logic [AW-1:0] retire_arf_id,
  input  logic [RW-1:0] retire_rob_id,
  input  logic          flush,
  output logic [AW:0]   n_renamed
);

  logic [ARF_N_ENTRIES-1:0] v_q, v_d;
  logic [RW-1:0]            tag_q [ARF_N_ENTRIES];
  logic [RW-1:0]            tag_d [ARF_N_ENTRIES];
  logic [AW:0]              n_renamed_q, n_renamed_d;

  logic rename_hit;
  logic release_hit;
  logic cnt_inc;
  logic cnt_dec;

  // Lookups see only the state before this edge; x0 is hardwired to "not renamed".
  assign src1_renamed = (src1_arf_id != '0) && v_q[src1_arf_id];
  assign src1_rob_id  = tag_q[src1_arf_id];
  assign src2_renamed = (src2_arf_id != '0) && v_q[src2_arf_id];
  assign src2_rob_id  = tag_q[src2_arf_id];
  assign n_renamed    = n_renamed_q;

  assign rename_hit  = dispatch_fire && dispatch_dst_valid && (dispatch_dst_arf_id != '0);
  assign release_hit = retire && (retire_arf_id != '0) && v_q[retire_arf_id]
                       && (tag_q[retire_arf_id] == retire_rob_id);

  // A release on the register being renamed this cycle is absorbed by the rename.
  assign cnt_inc = rename_hit && !v_q[dispatch_dst_arf_id];
  assign cnt_dec = release_hit && !(rename_hit && (dispatch_dst_arf_id == retire_arf_id));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    v_d         = v_q;
    tag_d       = tag_q;
    n_renamed_d = n_renamed_q;
    if (flush) begin
      v_d         = '0;
      n_renamed_d = '0;
    end else begin
      if (release_hit) v_d[retire_arf_id] = 1'b0;
      if (rename_hit) begin
        v_d[dispatch_dst_arf_id]   = 1'b1;
        tag_d[dispatch_dst_arf_id] = dispatch_rob_id;
      end
      n_renamed_d = n_renamed_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      n_renamed_q <= '0;
    end else begin
      v_q         <= v_d;
      n_renamed_q <= n_renamed_d;
    end
  end

  // NOTE: tags are storage qualified by v_q, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_rename_table.sv
// Scoreboarded bench for rename_table: directed scenarios then random traffic,
// checked against an array-based reference model of the alias table.
module tb_rename_table;

  localparam int AW = 5;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] src1_arf_id, src2_arf_id;
  logic          src1_renamed, src2_renamed;
  logic [RW-1:0] src1_rob_id, src2_rob_id;
  logic          dispatch_fire, dispatch_dst_valid;
  logic [AW-1:0] dispatch_dst_arf_id;
  logic [RW-1:0] dispatch_rob_id;
  logic          retire;
  logic [AW-1:0] retire_arf_id;
  logic [RW-1:0] retire_rob_id;
  logic          flush;
  logic [AW:0]   n_renamed;

  rename_table dut (
    .clk(clk), .rst(rst),
    .src1_arf_id(src1_arf_id), .src1_renamed(src1_renamed), .src1_rob_id(src1_rob_id),
    .src2_arf_id(src2_arf_id), .src2_renamed(src2_renamed), .src2_rob_id(src2_rob_id),
    .dispatch_fire(dispatch_fire), .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_rob_id(dispatch_rob_id),
    .retire(retire), .retire_arf_id(retire_arf_id), .retire_rob_id(retire_rob_id),
    .flush(flush), .n_renamed(n_renamed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] s1, s2;
    bit            fire, dv;
    logic [AW-1:0] dst;
    logic [RW-1:0] drob;
    bit            ret;
    logic [AW-1:0] rarf;
    logic [RW-1:0] rrob;
    bit            fl, rs;
  } stim_t;

  typedef struct {
    string         tag;
    bit            r1, r2;
    logic [RW-1:0] id1, id2;
    int            cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one valid flag and one tag per architectural register.
  bit            mv [32];
  logic [RW-1:0] mt [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 1; i < 32; i++) if (mv[i]) c++;
    return c;
  endfunction

  function automatic void model_step(input stim_t s);
    bit rel;
    if (s.rs || s.fl) begin
      for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    end else begin
      rel = s.ret && (s.rarf != 0) && mv[s.rarf] && (mt[s.rarf] == s.rrob);
      if (rel) mv[s.rarf] = 1'b0;
      if (s.fire && s.dv && (s.dst != 0)) begin
        mv[s.dst] = 1'b1;
        mt[s.dst] = s.drob;
      end
    end
  endfunction

  function automatic stim_t look(input logic [AW-1:0] a, input logic [AW-1:0] b);
    stim_t s;
    s = '{s1: a, s2: b, fire: 0, dv: 0, dst: '0, drob: '0, ret: 0, rarf: '0, rrob: '0, fl: 0, rs: 0};
    return s;
  endfunction

  // Called at posedge+1: drive inputs, queue the expected combinational response
  // from the model's current state, then advance the model across the next edge.
  task automatic apply(input string name, input stim_t s);
    exp_t e;
    src1_arf_id = s.s1;             src2_arf_id = s.s2;
    dispatch_fire = s.fire;         dispatch_dst_valid = s.dv;
    dispatch_dst_arf_id = s.dst;    dispatch_rob_id = s.drob;
    retire = s.ret;                 retire_arf_id = s.rarf;
    retire_rob_id = s.rrob;         flush = s.fl;
    rst = s.rs;
    e.tag = name;
    e.r1  = (s.s1 != 0) && mv[s.s1];
    e.r2  = (s.s2 != 0) && mv[s.s2];
    e.id1 = mt[s.s1];
    e.id2 = mt[s.s2];
    e.cnt = model_count();
    exp_q.push_back(e);
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so one queued expectation is consumed per negedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".src1_renamed"}, 32'(src1_renamed), 32'(e.r1));
      if (e.r1) check({e.tag, ".src1_rob_id"}, 32'(src1_rob_id), 32'(e.id1));
      check({e.tag, ".src2_renamed"}, 32'(src2_renamed), 32'(e.r2));
      if (e.r2) check({e.tag, ".src2_rob_id"}, 32'(src2_rob_id), 32'(e.id2));
      check({e.tag, ".n_renamed"}, 32'(n_renamed), 32'(e.cnt));
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    s = look(5'd0, 5'd0);
    src1_arf_id = '0; src2_arf_id = '0; dispatch_fire = 0; dispatch_dst_valid = 0;
    dispatch_dst_arf_id = '0; dispatch_rob_id = '0; retire = 0; retire_arf_id = '0;
    retire_rob_id = '0; flush = 0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state lookups.
    apply("reset", look(5'd5, 5'd0));

    // Rename dst 5 -> rob 3; same-cycle lookup of 5 still sees the old state.
    s = look(5'd5, 5'd5); s.fire = 1; s.dv = 1; s.dst = 5; s.drob = 3;
    apply("disp5", s);
    apply("look5", look(5'd5, 5'd0));

    // Newer producer rob 9 survives retire of stale rob 3.
    s = look(5'd5, 5'd1); s.fire = 1; s.dv = 1; s.dst = 5; s.drob = 9;
    apply("disp5b", s);
    s = look(5'd5, 5'd5); s.ret = 1; s.rarf = 5; s.rrob = 3;
    apply("ret_stale", s);
    s = look(5'd5, 5'd5); s.ret = 1; s.rarf = 5; s.rrob = 9;
    apply("ret_match", s);
    apply("after_ret", look(5'd5, 5'd7));

    // Rename wins over release on the same register; different registers both apply.
    s = look(5'd7, 5'd0); s.fire = 1; s.dv = 1; s.dst = 7; s.drob = 2;
    apply("disp7", s);
    s = look(5'd7, 5'd7); s.fire = 1; s.dv = 1; s.dst = 7; s.drob = 15; s.ret = 1; s.rarf = 7; s.rrob = 2;
    apply("same_reg", s);
    s = look(5'd7, 5'd8); s.fire = 1; s.dv = 1; s.dst = 8; s.drob = 1; s.ret = 1; s.rarf = 7; s.rrob = 15;
    apply("diff_reg", s);
    apply("after_diff", look(5'd7, 5'd8));

    // x0 is never renamed or released.
    s = look(5'd0, 5'd8); s.fire = 1; s.dv = 1; s.dst = 0; s.drob = 4; s.ret = 1; s.rarf = 0; s.rrob = 4;
    apply("x0", s);
    apply("x0_look", look(5'd0, 5'd8));

    // Fill every register with wrapping rob ids, then flush over a same-cycle dispatch.
    for (int i = 1; i < 32; i++) begin
      s = look(5'(i - 1), 5'(i)); s.fire = 1; s.dv = 1; s.dst = 5'(i); s.drob = 4'(i % 16);
      apply("fill", s);
    end
    apply("full", look(5'd31, 5'd17));
    s = look(5'd3, 5'd31); s.fire = 1; s.dv = 1; s.dst = 3; s.drob = 6; s.fl = 1;
    apply("flush", s);
    apply("after_flush", look(5'd3, 5'd31));

    // Mid-traffic reset.
    for (int i = 1; i < 6; i++) begin
      s = look(5'(i), 5'd0); s.fire = 1; s.dv = 1; s.dst = 5'(i); s.drob = 4'(i);
      apply("pre_rst", s);
    end
    s = look(5'd1, 5'd2); s.rs = 1; s.fire = 1; s.dv = 1; s.dst = 9; s.drob = 9;
    apply("rst_mid", s);
    apply("after_rst", look(5'd1, 5'd9));

    // Random traffic; retires usually target a live mapping so releases occur often.
    for (int n = 0; n < 3000; n++) begin
      s.s1   = 5'($urandom_range(0, 31));
      s.s2   = 5'($urandom_range(0, 31));
      s.fire = ($urandom_range(0, 99) < 60);
      s.dv   = ($urandom_range(0, 99) < 85);
      s.dst  = 5'($urandom_range(0, 31));
      s.drob = 4'($urandom_range(0, 15));
      s.ret  = ($urandom_range(0, 99) < 50);
      s.rarf = 5'($urandom_range(0, 31));
      s.rrob = ($urandom_range(0, 99) < 70) ? mt[s.rarf] : 4'($urandom_range(0, 15));
      s.fl   = ($urandom_range(0, 999) < 15);
      s.rs   = ($urandom_range(0, 999) < 5);
      apply("rand", s);
    end

    rst = 0; flush = 0; dispatch_fire = 0; retire = 0;
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_table.md
Name: rename_table

Overview:
- Register alias table in the dispatch stage, directly upstream of the ROB.
- For each architectural register it records whether the newest producer is still in flight and, if so, that producer's ROB id.
- Dispatch uses it to steer source operands to the ROB register-read ports or the ARF.
- It records the destination mapping of each dispatched instruction, and releases mappings on ROB retire or on a mispredict flush.

Parameters:
- ARF_N_ENTRIES, 32, number of architectural registers; entry 0 (x0) is never renamed.
- ROB_N_ENTRIES, 16, ROB depth; sets the ROB id width RW = $clog2(ROB_N_ENTRIES).
- AW, $clog2(ARF_N_ENTRIES), architectural id width (derived; not overridden).

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- src1_arf_id  in  AW  source 1 lookup index.
- src1_renamed  out  1  1 = source 1 is produced by an in-flight ROB entry.
- src1_rob_id  out  RW  producer ROB id for source 1; valid only when src1_renamed=1.
- src2_arf_id  in  AW  source 2 lookup index.
- src2_renamed  out  1  as src1_renamed, for source 2.
- src2_rob_id  out  RW  as src1_rob_id, for source 2.
- dispatch_fire  in  1  dispatch handshake completed this cycle (dispatch_valid & dispatch_ready).
- dispatch_dst_valid  in  1  the dispatching instruction writes a register.
- dispatch_dst_arf_id  in  AW  destination register.
- dispatch_rob_id  in  RW  ROB id allocated to this instruction by the ROB.
- retire  in  1  ROB head retiring this cycle.
- retire_arf_id  in  AW  destination of the retiring entry.
- retire_rob_id  in  RW  ROB id of the retiring entry.
- flush  in  1  branch/load mispredict flush.
- n_renamed  out  AW+1  count of entries whose valid bit = 1.

Behaviour:
- State: per entry i, a valid bit v[i] and a tag tag[i] (RW bits). All state is flops updated on the rising edge of clk.
- Reset (rst=1 at an edge): all v[i]=0, n_renamed=0. tag contents are don't-care. Reset overrides every other input in the same cycle.
- Lookups are purely combinational from the current state, with zero latency:
  - srcN_renamed = v[srcN_arf_id]; srcN_rob_id = tag[srcN_arf_id].
  - arf_id 0 always returns renamed=0.
  - No bypass of same-cycle dispatch or retire. An instruction's own destination never affects its own sources. A same-cycle retire is still visible as renamed=1, because the ROB entry still holds its data that cycle.
- Rename: when dispatch_fire & dispatch_dst_valid & (dispatch_dst_arf_id != 0), at the edge set v[d]=1 and tag[d]=dispatch_rob_id. Any older mapping is overwritten.
- Release: when retire & v[r] & (tag[r]==retire_rob_id) with r=retire_arf_id, clear v[r] at the edge.
  - If the tag does not match, a newer producer owns the entry and it is left unchanged.
  - Retire with r=0 is ignored.
- Simultaneous rename and release on the same register: the rename wins. Result is v=1 with the new tag.
- Simultaneous rename and release on different registers: both take effect.
- Flush: at the edge, all v[i]=0 and n_renamed=0. Any rename or retire in the same cycle is discarded. Priority is rst > flush > rename > release.
- n_renamed is a registered counter and must equal popcount(v) after every edge. Update rules:
  - +1 when a rename hits an entry with v=0.
  - -1 when a release clears an entry and no rename hits that same entry.
  - Both +1 and -1 in the same cycle give a net of 0.
  - Maximum value is ARF_N_ENTRIES-1; no overflow is possible.
- ROB-id wrap: tags are plain ROB indices. Uniqueness is guaranteed by the ROB never holding two live entries with the same id. The table performs no age comparison.

Test Plan:
1. Reset, then look up src1=5, src2=0 -> renamed=0/0, n_renamed=0. Assert rst for one cycle mid-traffic -> every entry clears next cycle.
2. Dispatch dst=5, rob_id=3 -> next cycle src1=5 gives renamed=1, rob_id=3, n_renamed=1. Same-cycle lookup of src1=5 still gives 0.
3. Dispatch dst=5 rob 3, then dst=5 rob 9, then retire arf 5 rob 3 -> entry stays (1, 9) and n_renamed stays 1. Retire arf 5 rob 9 -> entry cleared, n_renamed=0.
4. Same cycle: retire arf 7 rob 2 (tag matches) and dispatch dst=7 rob 15 -> entry (1, 15), n_renamed unchanged. Same cycle with dispatch dst=8 instead -> 7 cleared, 8 set, n_renamed unchanged.
5. Dispatch dst=0 rob 4, and retire arf 0 -> no state change; lookup of 0 gives renamed=0.
6. Fill registers 1..31 (rob ids cycling 0..15, wrapping) -> n_renamed=31. Then flush together with dispatch dst=3 -> next cycle all renamed=0, n_renamed=0.
